// File: rtl/mont_pkg.sv
// Shared types and helpers for the radix-2 Montgomery multiplier.
package mont_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRECOMP,
        LOOP,
        FSUB,
        DONE
    } state_t;

    // Addend chosen in LOOP, indexed by {a_i, q}.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'b00,
        SEL_M    = 2'b01,
        SEL_B    = 2'b10,
        SEL_BM   = 2'b11
    } sel_t;

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mont_addsub.sv
// Combinational add/subtract with borrow-out; one instance serves every datapath step.
module mont_addsub #(
    parameter int WIDTH = 514
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             borrow
);

    logic [WIDTH-1:0] op_b_eff;
    logic             carry;

    // Subtraction as a + ~b + 1; a missing carry-out means a < b.
    assign op_b_eff       = sub ? ~op_b : op_b;
    assign {carry, sum}   = {1'b0, op_a} + {1'b0, op_b_eff} + (WIDTH + 1)'(sub);
    assign borrow         = sub & ~carry;

endmodule

// File: rtl/mont_mul_r2.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M.
module mont_mul_r2
    import mont_pkg::*;
#(
    parameter int WIDTH     = 512,
    parameter int FINAL_SUB = 1
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic           busy,
    output logic           done,
    output logic [WIDTH:0] result
);

    localparam int  CW      = log2_ceil(WIDTH) + 1;
    localparam int  AW      = WIDTH + 2;
    localparam bit  DO_FSUB = (FINAL_SUB != 0);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [WIDTH:0]    c_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  m_reg;
    logic [WIDTH:0]    bm_reg;

    logic              accept;
    logic              q;
    sel_t              sel;
    logic [AW-1:0]     op_a;
    logic [AW-1:0]     op_b;
    logic              op_sub;
    logic [AW-1:0]     sum;
    logic              borrow;

    assign accept = ((state == IDLE) || (state == DONE)) && start;
    assign q      = c_reg[0] ^ (a_reg[0] & b_reg[0]);
    assign sel    = sel_t'({a_reg[0], q});
    assign result = c_reg;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        op_a   = {1'b0, c_reg};
        op_b   = '0;
        op_sub = 1'b0;
        case (state)
            PRECOMP: begin
                op_a = {2'b00, b_reg};
                op_b = {2'b00, m_reg};
            end
            FSUB: begin
                op_b   = {2'b00, m_reg};
                op_sub = 1'b1;
            end
            default: begin
                case (sel)
                    SEL_M:   op_b = {2'b00, m_reg};
                    SEL_B:   op_b = {2'b00, b_reg};
                    SEL_BM:  op_b = {1'b0, bm_reg};
                    default: op_b = '0;
                endcase
            end
        endcase
    end

    mont_addsub #(.WIDTH(AW)) u_addsub (
        .op_a   (op_a),
        .op_b   (op_b),
        .sub    (op_sub),
        .sum    (sum),
        .borrow (borrow)
    );

    // NOTE: operand registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= in_a;
            b_reg <= in_b;
            m_reg <= in_m;
        end else if (state == LOOP) begin
            a_reg <= a_reg >> 1;
        end
        if (state == PRECOMP) bm_reg <= sum[WIDTH:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            c_reg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= PRECOMP;
                        busy  <= 1'b1;
                        c_reg <= '0;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                PRECOMP: state <= LOOP;
                LOOP: begin
                    // Sum is WIDTH+2 bits; after halving it fits WIDTH+1.
                    c_reg <= sum[AW-1:1];
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FSUB;
                end
                FSUB: begin
                    if (DO_FSUB && !borrow) c_reg <= sum[WIDTH:0];
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
